dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder side of the pipeline's data-memory load/store interface.
- Accepts one load or store request from the MEM stage per handshake and inserts a programmable number of wait states.
- Performs byte/halfword/word access by funct3 on a little-endian byte-addressed array, then returns one response pulse.
- Its busy output is the pipeline's memory-stall source.

Parameters:
- DM_ADDRESS, 9, byte-address width; array holds 2**DM_ADDRESS bytes, organised as 32-bit words.
- DATA_W, 32, data width; only 32 is supported.
- WAIT_CYCLES, 1, wait states between acceptance and access; legal range 0..15.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_write  input  1  1 = store, 0 = load
- req_addr  input  DM_ADDRESS  byte address
- req_wdata  input  DATA_W  store data; the relevant lane is taken from the LSBs
- req_funct3  input  3  RISC-V load/store funct3
- req_ready  output  1  responder can accept a request
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  DATA_W  load result, sign- or zero-extended
- resp_err  output  1  misaligned access flag; tied 0 unless DMEM_MISALIGN_CHECK_EN is defined
- busy  output  1  request in flight

Behaviour:
- Clock and reset: clk, rising edge. reset is synchronous, active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, wait counter=0. Array contents are not cleared by reset.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, latch write, addr, wdata and funct3, and load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT:
  - Counter decrements each cycle; on counter==1, next state is ACCESS.
  - req_ready=0; req_valid is ignored and the bench must hold it.
- ACCESS:
  - The memory operation is performed at the edge leaving ACCESS.
  - Loads: resp_rdata is registered. Stores: lane bytes are written and resp_rdata=0.
  - The FSM returns to IDLE and resp_valid=1 for exactly the following cycle (the first IDLE cycle).
  - A new request is accepted in that same cycle (back-to-back).
- busy = (state != IDLE).
- Latency: acceptance edge T → resp_valid high in the cycle after edge T+WAIT_CYCLES+1. For WAIT_CYCLES=0 that is 2 cycles after req_valid is sampled.
- Load funct3 decoding, with lane = addr[1:0] little-endian:
  - 000 LB: byte, sign-extended.
  - 001 LH: halfword, sign-extended.
  - 010 LW: word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: halfword, zero-extended.
- Store funct3 decoding:
  - 000 SB: req_wdata[7:0] written to byte lane addr[1:0].
  - 001 SH: req_wdata[15:0] written to halfword addr[1].
  - 010 SW: full word written.
  - Unaffected bytes are unchanged.
- Reserved funct3 (011, 110, 111) executes as a word access.
- Default misalignment handling (feature off): offending low address bits are ignored.
  - Halfword: addr[0] is forced to 0.
  - Word: addr[1:0] is forced to 0.
- Word index = addr[DM_ADDRESS-1:2]; there is no wrap beyond the array.
- Reset while in WAIT or ACCESS:
  - The request is aborted with no write committed.
  - No resp_valid is issued; the FSM returns to IDLE.
- Reset asserted in the same cycle as req_valid: the request is not accepted.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - Misalignment conditions: halfword access with addr[0]=1, or word access with addr[1:0]≠0.
  - A misaligned request still follows the full FSM timing.
  - No write is performed and resp_rdata=0.
  - resp_err=1 together with resp_valid; it is 0 in all other cycles.
- Not defined: resp_err is constant 0 and the forced-alignment rule applies.

Test Plan:
- WAIT_CYCLES=0, SW addr 0x010 data 0xDEADBEEF, then LW 0x010 → write resp_valid 2 cycles after acceptance; load resp_rdata=0xDEADBEEF; busy high 1 cycle per request.
- Word 0x80FF7F01 at 0x020; LB 0x023, LBU 0x023, LH 0x022, LHU 0x022, LB 0x020 → 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF, 0x00000001.
- Word 0x11223344 at 0x040; SB 0x041 data 0xAA; SH 0x042 data 0xBEEF; LW 0x040 → 0xBEEFAA44.
- WAIT_CYCLES=3, LW accepted at edge T, req_valid held high → req_ready=0 for 4 cycles, resp_valid exactly at cycle T+5, next request accepted in that same cycle.
- WAIT_CYCLES=3, SW 0x050 data 0x12345678 over prior 0; reset asserted 2 cycles after acceptance → no resp_valid; outputs at reset values; a following LW 0x050 returns 0x00000000.
- Misaligned LW 0x046 with 0x11223344 at 0x044: feature off → resp_rdata=0x11223344, resp_err=0. Feature on → resp_rdata=0, resp_err=1, and a misaligned SH leaves memory unchanged.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory
// responder (slave). One request per handshake, one response pulse back.
interface dmem_responder_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) ();
    logic                  req_valid;
    logic                  req_write;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, performs
// a byte/halfword/word access on a little-endian word array and returns one
// response pulse. busy is the pipeline's memory-stall source.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN -- misaligned halfword/word
// accesses are flagged on resp_err and suppressed instead of being
// force-aligned.
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic              busy
);
    localparam int WORDS = 2 ** (DM_ADDRESS - 2);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t                state_reg;
    logic [3:0]            count_reg;
    logic                  write_reg;
    logic [DM_ADDRESS-1:0] addr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [2:0]            funct3_reg;

    logic                  req_ready_reg;
    logic                  resp_valid_reg;
    logic [DATA_W-1:0]     resp_rdata_reg;
    logic                  resp_err_reg;
    logic                  busy_reg;

    // Word array; contents survive reset.
    logic [DATA_W-1:0]     mem [WORDS];
    logic [DATA_W-1:0]     word_reg;

    logic                  accept;
    logic                  is_byte;
    logic                  is_half;
    logic                  misaligned;
    logic [1:0]            lane;
    logic [3:0]            byte_en;
    logic [DATA_W-1:0]     lane_wdata;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_W-1:0]     load_data;
    logic                  mem_we;

    assign accept = (state_reg == IDLE) && bus.req_valid;

    // Size decode: 00 byte, 01 halfword, everything else (incl. reserved) word.
    assign is_byte = (funct3_reg[1:0] == 2'b00);
    assign is_half = (funct3_reg[1:0] == 2'b01);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = (is_half && addr_reg[0]) ||
                        (!is_byte && !is_half && (addr_reg[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Offending low address bits are dropped, so halfword/word always align.
    always_comb begin
        lane       = 2'b00;
        byte_en    = 4'b1111;
        lane_wdata = wdata_reg;
        if (is_byte) begin
            lane       = addr_reg[1:0];
            byte_en    = 4'b0001 << addr_reg[1:0];
            lane_wdata = {4{wdata_reg[7:0]}};
        end else if (is_half) begin
            lane       = {addr_reg[1], 1'b0};
            byte_en    = addr_reg[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata_reg[15:0]}};
        end
    end

    // Extract and extend the load lane from the word read at acceptance.
    always_comb begin
        sel_byte = word_reg[8*lane +: 8];
        sel_half = addr_reg[1] ? word_reg[31:16] : word_reg[15:0];
        if (is_byte) begin
            load_data = funct3_reg[2] ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
        end else if (is_half) begin
            load_data = funct3_reg[2] ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
        end else begin
            load_data = word_reg;
        end
    end

    // A store commits only on a clean exit from ACCESS (reset aborts it).
    assign mem_we = (state_reg == ACCESS) && write_reg && !misaligned && !reset;

    // Registered read port: the addressed word is fetched at acceptance, and
    // no write can intervene before that request reaches ACCESS.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_reg <= mem[bus.req_addr[DM_ADDRESS-1:2]];
        end
    end

    // Byte-enabled write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[addr_reg[DM_ADDRESS-1:2]][8*i +: 8] <= lane_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= 4'd0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_reg     <= bus.req_write;
                        addr_reg      <= bus.req_addr;
                        wdata_reg     <= bus.req_wdata;
                        funct3_reg    <= bus.req_funct3;
                        count_reg     <= 4'(WAIT_CYCLES);
                        state_reg     <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end
                WAIT: begin
                    count_reg <= count_reg - 4'd1;
                    if (count_reg == 4'd1) begin
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_reg      <= IDLE;
                    req_ready_reg  <= 1'b1;
                    busy_reg       <= 1'b0;
                    resp_valid_reg <= 1'b1;
                    resp_err_reg   <= misaligned;
                    resp_rdata_reg <= (write_reg || misaligned) ? '0 : load_data;
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_err   = resp_err_reg;
    assign busy           = busy_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with WAIT_CYCLES=0 and one with 3.
// A request-level model (byte array + expected response cycle) is checked
// against both instances every cycle; directed tests add literal checks.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus0 ();
    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus1 ();
    logic busy0, busy1;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .busy(busy0));
    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .busy(busy1));

    logic        rv [2];
    logic        rw [2];
    logic [8:0]  ra [2];
    logic [31:0] rwd [2];
    logic [2:0]  rf [2];
    logic        vld [2];
    logic        rdy [2];
    logic        errv [2];
    logic        bsy [2];
    logic [31:0] rdat [2];

    assign bus0.req_valid = rv[0];  assign bus1.req_valid = rv[1];
    assign bus0.req_write = rw[0];  assign bus1.req_write = rw[1];
    assign bus0.req_addr = ra[0];   assign bus1.req_addr = ra[1];
    assign bus0.req_wdata = rwd[0]; assign bus1.req_wdata = rwd[1];
    assign bus0.req_funct3 = rf[0]; assign bus1.req_funct3 = rf[1];
    assign vld[0] = bus0.resp_valid;  assign vld[1] = bus1.resp_valid;
    assign rdy[0] = bus0.req_ready;   assign rdy[1] = bus1.req_ready;
    assign errv[0] = bus0.resp_err;   assign errv[1] = bus1.resp_err;
    assign rdat[0] = bus0.resp_rdata; assign rdat[1] = bus1.resp_rdata;
    assign bsy[0] = busy0;            assign bsy[1] = busy1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;
    int wc [2]  = '{0, 3};

    // Model state
    logic [7:0]  mm [2][512];
    bit          pend [2];
    int          acc_c [2];
    int          rsp_c [2];
    logic        rq_w [2];
    logic [8:0]  rq_a [2];
    logic [31:0] rq_wd [2];
    logic [2:0]  rq_f [2];
    bit          after_rst [2] = '{1'b1, 1'b1};
    int          acc_cnt [2] = '{0, 0};
    int          resp_cnt [2] = '{0, 0};
    int          busy_cnt [2] = '{0, 0};
    int          obs_cnt [2] = '{0, 0};
    int          obs_cyc [2];
    logic [31:0] obs_rdata [2];
    logic        obs_err [2];

    logic        eb, ev, ee;
    logic [31:0] ed;

    always @(posedge clk) cyc <= cyc + 1;

    // Execute request d against the byte-array model at its response time.
    task automatic model_exec(input int d, output logic [31:0] data, output logic err);
        int size;
        int base;
        logic [31:0] v;
        size = (rq_f[d][1:0] == 2'b00) ? 1 : (rq_f[d][1:0] == 2'b01) ? 2 : 4;
        err  = 1'b0;
        data = 32'd0;
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((size == 2 && rq_a[d][0]) || (size == 4 && rq_a[d][1:0] != 2'b00)) begin
            err = 1'b1;
            return;
        end
`endif
        base = (int'(rq_a[d]) / size) * size;
        if (rq_w[d]) begin
            for (int i = 0; i < size; i++) mm[d][base + i] = rq_wd[d][8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(mm[d][base + i]) << (8 * i));
            if (!rq_f[d][2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
            data = v;
        end
    endtask

    // Per-cycle compare of both DUTs against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            ev = pend[d] && (cyc == rsp_c[d]);
            eb = pend[d] && (cyc >= acc_c[d]) && (cyc < rsp_c[d]);
            ed = 32'd0;
            ee = 1'b0;
            if (ev) model_exec(d, ed, ee);
            if (chk_en) begin
                n_tests++;
                if (vld[d] !== ev || bsy[d] !== eb || rdy[d] !== ~eb ||
                    errv[d] !== (ev & ee) || ((ev || after_rst[d]) && rdat[d] !== ed)) begin
                    n_fail++;
                    $display("FAIL cycle_check dut%0d cyc %0d: got/expected valid %b/%b busy %b/%b ready %b/%b err %b/%b rdata %h/%h",
                             d, cyc, vld[d], ev, bsy[d], eb, rdy[d], ~eb, errv[d], ev & ee, rdat[d], ed);
                end
            end
            if (vld[d] === 1'b1) begin
                obs_rdata[d] = rdat[d];
                obs_err[d]   = errv[d];
                obs_cyc[d]   = cyc;
                obs_cnt[d]++;
            end
            if (bsy[d] === 1'b1) busy_cnt[d]++;
            if (ev) begin
                pend[d] = 1'b0;
                resp_cnt[d]++;
            end
            if (reset) begin
                pend[d]      = 1'b0;
                after_rst[d] = 1'b1;
            end else begin
                after_rst[d] = 1'b0;
                if (rv[d] && !eb) begin
                    pend[d]  = 1'b1;
                    acc_c[d] = cyc + 1;
                    rsp_c[d] = cyc + 1 + wc[d] + 1;
                    rq_w[d]  = rw[d];
                    rq_a[d]  = ra[d];
                    rq_wd[d] = rwd[d];
                    rq_f[d]  = rf[d];
                    acc_cnt[d]++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode 0: wait for response; 1: keep req_valid high and return after
    // acceptance; 2: drop req_valid and return after acceptance.
    task automatic req(input int d, input logic w, input logic [8:0] a,
                       input logic [31:0] wd, input logic [2:0] f, input int mode);
        int c0, r0, k;
        rw[d] = w; ra[d] = a; rwd[d] = wd; rf[d] = f; rv[d] = 1'b1;
        c0 = acc_cnt[d];
        k = 0;
        while (acc_cnt[d] == c0 && k < 60) begin @(posedge clk); #2; k++; end
        if (acc_cnt[d] == c0) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout dut%0d addr %h: got no acceptance required acceptance", d, a);
        end
        if (mode != 1) rv[d] = 1'b0;
        if (mode == 0) begin
            r0 = resp_cnt[d];
            k = 0;
            while (resp_cnt[d] == r0 && k < 60) begin @(posedge clk); #2; k++; end
            if (resp_cnt[d] == r0) begin
                n_tests++; n_fail++;
                $display("FAIL resp_timeout dut%0d addr %h: got no response required response", d, a);
            end
        end
        $display("[TB] dut%0d %s addr %h f3 %b wdata %h -> rdata %h err %b",
                 d, w ? "ST" : "LD", a, f, wd, obs_rdata[d], obs_err[d]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    logic [8:0]  la [5] = '{9'h023, 9'h023, 9'h022, 9'h022, 9'h020};
    logic [2:0]  lf [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] le [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000001};

    initial begin
        int b0, a1, a2, v0;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = '0; rwd[d] = '0; rf[d] = '0;
        end
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // WAIT_CYCLES=0: store then load back
        b0 = busy_cnt[0];
        req(0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 0);
        check("w0_store_latency", 32'(obs_cyc[0] - acc_c[0]), 32'd1);
        check("w0_store_busy_cycles", 32'(busy_cnt[0] - b0), 32'd1);
        req(0, 1'b0, 9'h010, 32'd0, 3'b010, 0);
        check("w0_lw_data", obs_rdata[0], 32'hDEADBEEF);
        check("w0_lw_latency", 32'(obs_cyc[0] - acc_c[0]), 32'd1);

        // Sub-word loads with sign/zero extension
        req(0, 1'b1, 9'h020, 32'h80FF7F01, 3'b010, 0);
        for (int i = 0; i < 5; i++) begin
            req(0, 1'b0, la[i], 32'd0, lf[i], 0);
            check($sformatf("subword_load_%0d", i), obs_rdata[0], le[i]);
        end

        // Sub-word stores merge into an existing word
        req(0, 1'b1, 9'h040, 32'h11223344, 3'b010, 0);
        req(0, 1'b1, 9'h041, 32'h000000AA, 3'b000, 0);
        req(0, 1'b1, 9'h042, 32'h0000BEEF, 3'b001, 0);
        req(0, 1'b0, 9'h040, 32'd0, 3'b010, 0);
        check("sb_sh_merge", obs_rdata[0], 32'hBEEFAA44);

        // Reserved funct3 as word access, top word of the array
        req(0, 1'b0, 9'h040, 32'd0, 3'b011, 0);
        check("reserved_load_word", obs_rdata[0], 32'hBEEFAA44);
        req(0, 1'b1, 9'h1FC, 32'hA5A55A5A, 3'b111, 0);
        req(0, 1'b0, 9'h1FC, 32'd0, 3'b010, 0);
        check("top_word", obs_rdata[0], 32'hA5A55A5A);

        // Misaligned accesses
        req(0, 1'b1, 9'h044, 32'h11223344, 3'b010, 0);
        req(0, 1'b0, 9'h046, 32'd0, 3'b010, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("misaligned_lw_data", obs_rdata[0], 32'h00000000);
        check("misaligned_lw_err", 32'(obs_err[0]), 32'd1);
`else
        check("misaligned_lw_data", obs_rdata[0], 32'h11223344);
        check("misaligned_lw_err", 32'(obs_err[0]), 32'd0);
`endif
        req(0, 1'b1, 9'h045, 32'h0000BEEF, 3'b001, 0);
        req(0, 1'b0, 9'h044, 32'd0, 3'b010, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("misaligned_sh_effect", obs_rdata[0], 32'h11223344);
`else
        check("misaligned_sh_effect", obs_rdata[0], 32'h1122BEEF);
`endif

        // WAIT_CYCLES=3: back-to-back with req_valid held high
        req(1, 1'b1, 9'h060, 32'hCAFEF00D, 3'b010, 0);
        b0 = busy_cnt[1];
        req(1, 1'b0, 9'h060, 32'd0, 3'b010, 1);
        a1 = acc_c[1];
        req(1, 1'b0, 9'h060, 32'd0, 3'b010, 0);
        a2 = acc_c[1];
        check("b2b_accept_gap", 32'(a2 - a1), 32'd5);
        check("b2b_second_data", obs_rdata[1], 32'hCAFEF00D);
        check("w3_latency", 32'(obs_cyc[1] - a2), 32'd4);
        check("w3_busy_cycles", 32'(busy_cnt[1] - b0), 32'd8);

        // Reset during WAIT aborts the store
        req(1, 1'b1, 9'h050, 32'h00000000, 3'b010, 0);
        v0 = obs_cnt[1];
        req(1, 1'b1, 9'h050, 32'h12345678, 3'b010, 2);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("abort_no_resp", 32'(obs_cnt[1] - v0), 32'd0);
        req(1, 1'b0, 9'h050, 32'd0, 3'b010, 0);
        check("abort_no_write", obs_rdata[1], 32'h00000000);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
